multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 inst  in  32  instruction register contents; opcode=inst[31:26], funct=inst[5:0]; valid from DECODE onward.
REQ-005 zero  in  1  ALU zero flag; sampled only in EXEC of beq.
REQ-006 mem_ack  in  1  memory completion for current mem_req.
REQ-007 mem_req  out  1  memory access request, held until mem_ack.
REQ-008 mem_sel  out  1  0 = instruction fetch, 1 = data access.
REQ-009 IRWrite  out  1  load instruction register.
REQ-010 PCWrite  out  1  update PC with NPC result.
REQ-011 NPCOp  out  2  00 PC+4, 01 beq target, 10 jump target.
REQ-012 ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI.
REQ-013 ALUSrc  out  1  0 = register operand, 1 = 32-bit extended immediate.
REQ-014 RegDst  out  1  1 = rd, 0 = rt as write register.
REQ-015 MemtoReg  out  1  1 = data memory output to register file.
REQ-016 MemWrite  out  1  data memory write strobe.
REQ-017 RegWrite  out  1  register file write strobe.
REQ-018 illegal  out  1  one-cycle pulse on an unsupported instruction.
REQ-019 instr_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-020 States: FETCH, DECODE, EXEC, MEM, WB; outputs decoded combinationally from state, inst and mem_ack.
REQ-021 Supported instructions: opcode 0x00 with funct addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A; ori 0x0D; lui 0x0F; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-022 FETCH: mem_req=1, mem_sel=0; on mem_ack, IRWrite=1 for that cycle and go to DECODE; otherwise stay in FETCH.
REQ-023 DECODE: one cycle, no strobes; supported instruction goes to EXEC.
REQ-024 Unsupported instruction in DECODE: illegal=1, PCWrite=1, NPCOp=00, no other writes; next state FETCH.
REQ-025 EXEC: ALUOp/ALUSrc driven per instruction; lw and sw use ADD with ALUSrc=1; beq uses SUB with ALUSrc=0.
REQ-026 EXEC, beq: PCWrite=1, NPCOp=01 if zero=1 else 00; next state FETCH.
REQ-027 EXEC, j: PCWrite=1, NPCOp=10; next state FETCH.
REQ-028 EXEC exits: lw/sw go to MEM; R-type, ori and lui go to WB.
REQ-029 MEM: mem_req=1, mem_sel=1; MemWrite=1 for sw throughout the state; ALUOp=ADD and ALUSrc=1 held; wait for mem_ack.
REQ-030 MEM on mem_ack: sw asserts PCWrite=1, NPCOp=00 and goes to FETCH; lw goes to WB.
REQ-031 WB: RegWrite=1, PCWrite=1, NPCOp=00, one cycle, next state FETCH.
REQ-032 WB register and data selection: RegDst=1 only for R-type; MemtoReg=1 only for lw; ALUOp/ALUSrc held from EXEC.
REQ-033 Latency with mem_ack returned in the same cycle: R/ori/lui 4 cycles, lw 5, sw 4, beq 3, j 3; each cycle mem_ack is late adds one cycle.
REQ-034 Exactly one PCWrite pulse per instruction, including illegal ones.
REQ-035 mem_ack outside FETCH/MEM: ignored.
REQ-036 Unused encodings: unused state encodings recover to FETCH on the next edge.
REQ-037 Unused output encodings: ALUOp and NPCOp never present unused encodings.

Reset
REQ-038 While rst=1: all outputs are 0, including mem_req; instr_cnt=0.
REQ-039 First edge after rst deasserts: state FETCH.
REQ-040 rst in any state, including mid-MEM with an outstanding mem_req: return to FETCH on the next edge with no write strobe asserted in that cycle.

Configuration
REQ-041 Macro CTRL_INSTR_CNT_EN compiled in: instr_cnt increments by 1 in every cycle PCWrite=1, excluding illegal; wraps 0xFFFFFFFF->0.
REQ-042 Macro CTRL_INSTR_CNT_EN compiled out: instr_cnt is constant 0 and no counter register exists.

Verification
REQ-043 mem_ack tied 1, inst=addu $3,$1,$2 (0x00221821) -> states F,D,E,W; WB: RegWrite=1, RegDst=1, ALUOp=000, PCWrite=1, NPCOp=00.
REQ-044 lw (0x8C220004) with mem_ack delayed 2 cycles in MEM -> 7 cycles total; WB: MemtoReg=1, RegWrite=1, ALUSrc=1.
REQ-045 beq (0x10220003) with zero=1 -> EXEC: PCWrite=1, NPCOp=01; repeat with zero=0 -> NPCOp=00; 3 cycles each.
REQ-046 sw (0xAC220008) -> MemWrite=1 only in MEM; PCWrite coincides with mem_ack; RegWrite never asserted.
REQ-047 inst=0xFC000000 -> illegal=1 and PCWrite=1 in DECODE, then FETCH; with the macro compiled in, instr_cnt is unchanged.
REQ-048 rst=1 during MEM of sw with mem_ack=0 -> next cycle mem_req=0, MemWrite=0, state FETCH; with the macro compiled in, 5 retired instructions -> instr_cnt=5.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencer with combinational strobes.
// Optional retired-instruction counter enabled by defining CTRL_INSTR_CNT_EN.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  NPCOp,
  output logic [2:0]  ALUOp,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  state_t     state_q;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_r, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0] alu_op_dec;
  logic       alu_src_dec;
  logic       unused_inst_bits;

  assign opcode           = inst[31:26];
  assign funct            = inst[5:0];
  assign unused_inst_bits = ^inst[25:6];

  assign is_ori = (opcode == OP_ORI);
  assign is_lui = (opcode == OP_LUI);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_j   = (opcode == OP_J);
  assign legal  = is_r | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

  always_comb begin
    is_r        = 1'b0;
    alu_op_dec  = ALU_ADD;
    alu_src_dec = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin is_r = 1'b1; alu_op_dec = ALU_ADD; end
          FN_SUBU: begin is_r = 1'b1; alu_op_dec = ALU_SUB; end
          FN_AND:  begin is_r = 1'b1; alu_op_dec = ALU_AND; end
          FN_OR:   begin is_r = 1'b1; alu_op_dec = ALU_OR;  end
          FN_SLT:  begin is_r = 1'b1; alu_op_dec = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ORI:       begin alu_op_dec = ALU_OR;  alu_src_dec = 1'b1; end
      OP_LUI:       begin alu_op_dec = ALU_LUI; alu_src_dec = 1'b1; end
      OP_LW, OP_SW: begin alu_op_dec = ALU_ADD; alu_src_dec = 1'b1; end
      OP_BEQ:       begin alu_op_dec = ALU_SUB; alu_src_dec = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ack) state_q <= S_DECODE;
        S_DECODE: state_q <= legal ? S_EXEC : S_FETCH;
        S_EXEC: begin
          if (is_lw || is_sw)       state_q <= S_MEM;
          else if (is_beq || is_j)  state_q <= S_FETCH;
          else                      state_q <= S_WB;
        end
        S_MEM:    if (mem_ack) state_q <= is_lw ? S_WB : S_FETCH;
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes depend on mem_ack/zero in the same cycle, so they stay combinational and are masked by rst.
  always_comb begin
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_SEQ;
    ALUOp    = ALU_ADD;
    ALUSrc   = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ack;
        end
        S_DECODE: begin
          if (!legal) begin
            illegal = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_EXEC: begin
          ALUOp  = alu_op_dec;
          ALUSrc = alu_src_dec;
          if (is_beq) begin
            PCWrite = 1'b1;
            NPCOp   = zero ? NPC_BEQ : NPC_SEQ;
          end else if (is_j) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JMP;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_sel  = 1'b1;
          ALUOp    = ALU_ADD;
          ALUSrc   = 1'b1;
          MemWrite = is_sw;
          PCWrite  = is_sw & mem_ack;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          RegDst   = is_r;
          MemtoReg = is_lw;
          ALUOp    = alu_op_dec;
          ALUSrc   = alu_src_dec;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_INSTR_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (PCWrite && !illegal) cnt_q <= cnt_q + 32'd1;
  end

  assign instr_cnt = rst ? '0 : cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed-vector bench for multi_cycle_ctrl; follows CTRL_INSTR_CNT_EN for counter expectations.
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_sel, IRWrite, PCWrite;
  logic [1:0]  NPCOp;
  logic [2:0]  ALUOp;
  logic        ALUSrc, RegDst, MemtoReg, MemWrite, RegWrite, illegal;
  logic [31:0] instr_cnt;
  logic [14:0] ctl;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_cnt = '0;

`ifdef CTRL_INSTR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {mem_req, mem_sel, IRWrite, PCWrite, NPCOp, ALUOp, ALUSrc, RegDst, MemtoReg, MemWrite, RegWrite, illegal}
  localparam logic [14:0] F_ACK  = 15'h5000;
  localparam logic [14:0] F_WAIT = 15'h4000;

  assign ctl = {mem_req, mem_sel, IRWrite, PCWrite, NPCOp, ALUOp,
                ALUSrc, RegDst, MemtoReg, MemWrite, RegWrite, illegal};

  multi_cycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .zero      (zero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .NPCOp     (NPCOp),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] v(input logic req, input logic sel, input logic ir,
                                    input logic pcw, input logic [1:0] npc, input logic [2:0] alu,
                                    input logic src, input logic rd, input logic m2r,
                                    input logic mw, input logic rw, input logic ill);
    return {req, sel, ir, pcw, npc, alu, src, rd, m2r, mw, rw, ill};
  endfunction

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; zero = 1'b1; inst = 32'h00221821;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if (ctl !== 15'h0000) begin
        nerr++; $display("FAIL reset_ctl cyc%0d got %b want %b", i, ctl, 15'h0000);
      end
      nvec++;
      if (instr_cnt !== 32'h0) begin
        nerr++; $display("FAIL reset_cnt cyc%0d got %h want %h", i, instr_cnt, 32'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ack = 1'b0; zero = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    nvec++;
    if (ctl !== F_WAIT) begin
      nerr++; $display("FAIL reset_exit_fetch got %b want %b", ctl, F_WAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [31:0] ops [5];
    logic [14:0] e [5];
    logic [2:0]  a;
    ops = '{32'h00221821, 32'h00221823, 32'h00221824, 32'h00221825, 32'h0022182A};
    for (int k = 0; k < 5; k++) begin
      a = 3'(k);
      e = '{F_ACK, 15'h0000, v(0,0,0,0,2'b00,a,0,0,0,0,0,0),
            v(0,0,0,1,2'b00,a,0,1,0,0,1,0), F_WAIT};
      inst = ops[k];
      if (CNT_EN) exp_cnt++;
      for (int i = 0; i < 5; i++) begin
        mem_ack = (i < 4);
        @(negedge clk);
        nvec++;
        if (ctl !== e[i]) begin
          nerr++; $display("FAIL rtype op%0d cyc%0d got %b want %b", k, i, ctl, e[i]);
        end
        if (i == 4) begin
          nvec++;
          if (instr_cnt !== exp_cnt) begin
            nerr++; $display("FAIL rtype_cnt op%0d got %0d want %0d", k, instr_cnt, exp_cnt);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_imm();
    logic [31:0] ops [2];
    logic [2:0]  alus [2];
    logic [14:0] e [5];
    ops  = '{32'h34220005, 32'h3C020005};
    alus = '{3'b011, 3'b101};
    for (int k = 0; k < 2; k++) begin
      e = '{F_ACK, 15'h0000, v(0,0,0,0,2'b00,alus[k],1,0,0,0,0,0),
            v(0,0,0,1,2'b00,alus[k],1,0,0,0,1,0), F_WAIT};
      inst = ops[k];
      if (CNT_EN) exp_cnt++;
      for (int i = 0; i < 5; i++) begin
        mem_ack = (i == 0);
        @(negedge clk);
        nvec++;
        if (ctl !== e[i]) begin
          nerr++; $display("FAIL imm op%0d cyc%0d got %b want %b", k, i, ctl, e[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [14:0] e [8];
    logic        ack [8];
    logic [14:0] mw;
    mw  = v(1,1,0,0,2'b00,3'b000,1,0,0,0,0,0);
    e   = '{F_ACK, 15'h0000, v(0,0,0,0,2'b00,3'b000,1,0,0,0,0,0), mw, mw, mw,
            v(0,0,0,1,2'b00,3'b000,1,0,1,0,1,0), F_WAIT};
    ack = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    inst = 32'h8C220004;
    if (CNT_EN) exp_cnt++;
    for (int i = 0; i < 8; i++) begin
      mem_ack = ack[i];
      @(negedge clk);
      nvec++;
      if (ctl !== e[i]) begin
        nerr++; $display("FAIL lw_wait cyc%0d got %b want %b", i, ctl, e[i]);
      end
      if (i == 7) begin
        nvec++;
        if (instr_cnt !== exp_cnt) begin
          nerr++; $display("FAIL lw_cnt got %0d want %0d", instr_cnt, exp_cnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [14:0] e [5];
    logic        ack [5];
    logic        zr [5];
    inst = 32'h10220003;
    ack  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      // Second pass holds zero high everywhere except EXEC, where it is actually sampled.
      if (k == 0) zr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      else        zr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      e = '{F_WAIT, F_ACK, 15'h0000,
            v(0,0,0,1,(k == 0) ? 2'b01 : 2'b00,3'b001,0,0,0,0,0,0), F_WAIT};
      if (CNT_EN) exp_cnt++;
      for (int i = 0; i < 5; i++) begin
        mem_ack = ack[i];
        zero    = zr[i];
        @(negedge clk);
        nvec++;
        if (ctl !== e[i]) begin
          nerr++; $display("FAIL beq_z%0d cyc%0d got %b want %b", 1 - k, i, ctl, e[i]);
        end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [14:0] e [4];
    e = '{F_ACK, 15'h0000, v(0,0,0,1,2'b10,3'b000,0,0,0,0,0,0), F_WAIT};
    inst = 32'h08000010;
    if (CNT_EN) exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i < 3);
      @(negedge clk);
      nvec++;
      if (ctl !== e[i]) begin
        nerr++; $display("FAIL jump cyc%0d got %b want %b", i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [14:0] e [6];
    logic        ack [6];
    e   = '{F_ACK, 15'h0000, v(0,0,0,0,2'b00,3'b000,1,0,0,0,0,0),
            v(1,1,0,0,2'b00,3'b000,1,0,0,1,0,0), v(1,1,0,1,2'b00,3'b000,1,0,0,1,0,0), F_WAIT};
    ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    inst = 32'hAC220008;
    if (CNT_EN) exp_cnt++;
    for (int i = 0; i < 6; i++) begin
      mem_ack = ack[i];
      @(negedge clk);
      nvec++;
      if (ctl !== e[i]) begin
        nerr++; $display("FAIL sw cyc%0d got %b want %b", i, ctl, e[i]);
      end
      if (i == 5) begin
        nvec++;
        if (instr_cnt !== exp_cnt) begin
          nerr++; $display("FAIL sw_cnt got %0d want %0d", instr_cnt, exp_cnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ops [3];
    logic [14:0] e [3];
    ops = '{32'hFC000000, 32'h00000000, 32'h00221822};
    e   = '{F_ACK, v(0,0,0,1,2'b00,3'b000,0,0,0,0,0,1), F_WAIT};
    for (int k = 0; k < 3; k++) begin
      inst = ops[k];
      for (int i = 0; i < 3; i++) begin
        mem_ack = (i < 2);
        @(negedge clk);
        nvec++;
        if (ctl !== e[i]) begin
          nerr++; $display("FAIL illegal op%0d cyc%0d got %b want %b", k, i, ctl, e[i]);
        end
        if (i == 2) begin
          nvec++;
          if (instr_cnt !== exp_cnt) begin
            nerr++; $display("FAIL illegal_cnt op%0d got %0d want %0d", k, instr_cnt, exp_cnt);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_rst_mid_mem();
    logic [14:0] e [6];
    logic        ack [6];
    logic        r [6];
    e   = '{F_ACK, 15'h0000, v(0,0,0,0,2'b00,3'b000,1,0,0,0,0,0),
            v(1,1,0,0,2'b00,3'b000,1,0,0,1,0,0), 15'h0000, F_WAIT};
    ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    r   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    inst = 32'hAC220008;
    for (int i = 0; i < 6; i++) begin
      mem_ack = ack[i];
      rst     = r[i];
      if (r[i]) exp_cnt = '0;
      @(negedge clk);
      nvec++;
      if (ctl !== e[i]) begin
        nerr++; $display("FAIL rst_mid_mem cyc%0d got %b want %b", i, ctl, e[i]);
      end
      if (i >= 4) begin
        nvec++;
        if (instr_cnt !== exp_cnt) begin
          nerr++; $display("FAIL rst_mid_mem_cnt cyc%0d got %0d want %0d", i, instr_cnt, exp_cnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; inst = '0; zero = 1'b0; mem_ack = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_imm();
    test_lw_wait();
    test_beq();
    test_jump();
    test_sw();
    test_illegal();
    test_rst_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
